alu_seq_issue: RTL
==================

# alu_seq_issue

Upstream issue stage for the 16-bit ALU: accepts 16-bit instruction words over a valid/ready handshake, reads operands from an 8×16 register file, drives the ALU's `a`/`b`/`opcode` inputs, and captures its result and flags. Results are written back to the register file. The block owns architectural register and flag state. The ALU stays a separate combinational instance wired alongside it.

## Interface
- `DATA_W`, 16: datapath width; must equal ALU width.
- `REG_N`, 8: register count; the instruction format fixes the address width at 3.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: block can accept.
- `instr` in 16: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
- `alu_a`, `alu_b` out 16: operands to the ALU.
- `alu_opcode` out 4: opcode to the ALU.
- `alu_r` in 16: ALU result.
- `alu_flag_c`, `alu_flag_z` in 1: ALU compare flags.
- `host_we` in 1: host register write strobe.
- `host_addr` in 3: host write address.
- `host_data` in 16: host write data.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out 16: combinational read of `reg[dbg_addr]`.
- `done` out 1: one-cycle pulse per retired instruction.
- `result` out 16: last written-back result.
- `flag_c`, `flag_z` out 1: architectural flags.
- `err_div0` out 1: sticky divide-by-zero error.

## Operation
- States:
  - IDLE: `instr_ready`=1. On `instr_valid`, latch the opcode and rd, latch `reg[rs1]`→`op_a_q` and `reg[rs2]`→`op_b_q`, then go to EXEC.
  - EXEC: `instr_ready`=0. `alu_a`/`alu_b`/`alu_opcode` are driven from the latched registers at all times, in every state. At the end of the cycle, retire the instruction and go to IDLE.
- Retire rules:
  - Opcodes 0000–1110 with a non-zero divisor: `reg[rd]`←`alu_r`, `result`←`alu_r`, `flag_z`←(`alu_r`==0), `flag_c` unchanged.
  - Opcode 1111 (compare): no register write and `result` unchanged. `flag_c`←`alu_flag_c`, `flag_z`←`alu_flag_z`.
  - Opcode 0010 with `op_b_q`==0: no register write, `result` and flags unchanged, `err_div0`←1. `err_div0` stays set until reset.
  - Every retire pulses `done` in the following cycle.
- Host write:
  - Honoured in any state; `reg[host_addr]`←`host_data` at the edge.
  - Same edge as an EXEC writeback to the same address: the ALU writeback wins and the host write is dropped.
  - Different addresses on the same edge: both writes happen.
- Operands are read at accept time. A host write on the accept edge is therefore not seen by that instruction.
- All registers are general purpose; there is no hardwired zero register.

## Timing
- Reset values: all registers 0, state IDLE, `result`=0, `flag_c`=0, `flag_z`=0, `err_div0`=0, `done`=0. `instr_ready`=0 while `rst` is high and 1 in the first cycle after.
- Accept at edge T. EXEC occupies cycle T..T+1. Retire happens at edge T+1. `done`=1 during cycle T+1..T+2.
- Throughput: one instruction per 2 cycles. A new instruction may be accepted at edge T+2, the same cycle in which `done` is high.
- No hazards: writeback at T+1 is visible to an operand read at T+2.
- `rst` asserted mid-EXEC: the in-flight instruction is discarded, with no writeback and no `done`.
- `instr` is sampled only on the accept edge, so changes to it during EXEC have no effect.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode constants `OP_ADD`…`OP_CMP` (0000–1111);
  - the state enum (IDLE, EXEC);
  - instruction field bit positions.
- Sub-module `alu_regfile`:
  - 8×16 flops;
  - two combinational read ports plus the debug read port;
  - one write port with the EXEC-over-host priority mux.
- Top: FSM, operand/opcode latches, retire logic, flag and error registers.

## Test plan
- Load via host r1=0x0005, r2=0x0003. Issue ADD rd=3, rs1=1, rs2=2 → `done` 2 cycles after accept, r3=0x0008, `result`=0x0008, `flag_z`=0.
- SUB with r1=r2=0x0005 into r4 → r4=0x0000, `flag_z`=1. Then CMP r1,r2 → r4 unchanged, flags equal ALU flag outputs.
- DIV with r2=0 → no register write, `err_div0`=1 and it persists across later valid instructions until `rst`.
- Back-to-back: ADD r5=r1+r2, then the next instruction reads r5 at the first allowed accept → sees 0x0008, and `instr_ready` toggles 1/0 each cycle.
- Host write to r3 on the same edge as ADD writeback to r3 → r3 holds the ALU value. Host write to r6 on that edge → r6 updated too.
- `rst` asserted during EXEC → no `done`, rd unchanged, all outputs 0, `instr_ready`=1 the cycle after `rst` drops.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the ALU issue stage. Holds the opcode
//               map, the issue FSM state encoding and the bit positions of
//               the fields in the 16-bit instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Instruction field geometry: [15:12] opcode, [11:9] rd, [8:6] rs1,
    // [5:3] rs2, [2:0] reserved.
    localparam int OPC_W  = 4;
    localparam int ADDR_W = 3;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;

    // Opcode map shared with the ALU
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'b0111;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_ROL  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_ROR  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_INC  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_DEC  = 4'b1101;
    localparam logic [OPC_W-1:0] OP_PASS = 4'b1110;
    localparam logic [OPC_W-1:0] OP_CMP  = 4'b1111;

    // Issue FSM states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : General-purpose register file for the ALU issue stage.
//               REG_N x DATA_W flops, two combinational operand read ports,
//               one combinational debug read port. Each register takes the
//               execute writeback when addressed by it, otherwise the host
//               write; distinct addresses on one edge both land.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               i_rs1_addr / o_rs1_data  - operand A read port
//               i_rs2_addr / o_rs2_data  - operand B read port
//               i_dbg_addr / o_dbg_data  - debug read port
//               i_exec_we/addr/data      - execute writeback (high priority)
//               i_host_we/addr/data      - host write (low priority)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic [DATA_W-1:0] o_rs2_data,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data,
    input  logic              i_exec_we,
    input  logic [ADDR_W-1:0] i_exec_addr,
    input  logic [DATA_W-1:0] i_exec_data,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_data
);

    logic [DATA_W-1:0] r_regs [REG_N];

    generate
        for (genvar i = 0; i < REG_N; i++) begin : g_reg
            logic w_exec_hit;
            logic w_host_hit;
            assign w_exec_hit = i_exec_we && (i_exec_addr == ADDR_W'(i));
            assign w_host_hit = i_host_we && (i_host_addr == ADDR_W'(i));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_regs[i] <= '0;
                end else if (w_exec_hit) begin
                    r_regs[i] <= i_exec_data;
                end else if (w_host_hit) begin
                    r_regs[i] <= i_host_data;
                end
            end
        end
    endgenerate

    assign o_rs1_data = r_regs[i_rs1_addr];
    assign o_rs2_data = r_regs[i_rs2_addr];
    assign o_dbg_data = r_regs[i_dbg_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_seq_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_issue
// Description : Issue stage for the external combinational 16-bit ALU.
//               Accepts an instruction over valid/ready, reads both operands
//               at accept time, presents them to the ALU for one EXEC cycle
//               and retires the result into the register file, the result
//               register and the architectural flags. Two cycles per
//               instruction.
// Ports       : clk, rst                      - clock, synchronous reset
//               instr_valid/instr_ready/instr - instruction handshake
//               alu_a, alu_b, alu_opcode      - ALU operand drive
//               alu_r, alu_flag_c, alu_flag_z - ALU result / compare flags
//               host_we, host_addr, host_data - host register write
//               dbg_addr, dbg_data            - debug register read
//               done                          - one-cycle retire pulse
//               result, flag_c, flag_z        - architectural state
//               err_div0                      - sticky divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_issue
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_flag_c,
    input  logic              alu_flag_z,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              err_div0
);

    localparam logic [0:0] c_ST_IDLE = S_IDLE;
    localparam logic [0:0] c_ST_EXEC = S_EXEC;

    logic [0:0]        r_state;
    logic [OPC_W-1:0]  r_opcode;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_c;
    logic              r_flag_z;
    logic              r_err_div0;
    logic              r_done;

    logic              w_idle;
    logic              w_exec;
    logic              w_is_cmp;
    logic              w_is_div0;
    logic              w_wb;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic              w_unused_bits;

    // Reserved instruction bits carry no meaning
    assign w_unused_bits = ^instr[RS2_LO-1:0];

    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_exec    = (r_state == c_ST_EXEC);
    assign w_is_cmp  = (r_opcode == OP_CMP);
    assign w_is_div0 = (r_opcode == OP_DIV) && (r_op_b == '0);
    // Compare and faulted divides retire without touching the register file
    assign w_wb      = w_exec && !w_is_cmp && !w_is_div0;

    // Ready drops combinationally with rst so nothing is offered a handshake
    // that the reset edge would then discard.
    assign instr_ready = w_idle && !rst;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rs1_addr  (instr[RS1_HI:RS1_LO]),
        .o_rs1_data  (w_rs1_data),
        .i_rs2_addr  (instr[RS2_HI:RS2_LO]),
        .o_rs2_data  (w_rs2_data),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data),
        .i_exec_we   (w_wb),
        .i_exec_addr (r_rd),
        .i_exec_data (alu_r),
        .i_host_we   (host_we),
        .i_host_addr (host_addr),
        .i_host_data (host_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_opcode   <= '0;
            r_rd       <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_err_div0 <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (instr_valid) begin
                        r_opcode <= instr[OPC_HI:OPC_LO];
                        r_rd     <= instr[RD_HI:RD_LO];
                        r_op_a   <= w_rs1_data;
                        r_op_b   <= w_rs2_data;
                        r_state  <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b1;
                    if (w_is_cmp) begin
                        r_flag_c <= alu_flag_c;
                        r_flag_z <= alu_flag_z;
                    end else if (w_is_div0) begin
                        r_err_div0 <= 1'b1;
                    end else begin
                        r_result <= alu_r;
                        r_flag_z <= (alu_r == '0);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // The ALU sees the latched operands continuously, not just in EXEC
    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign alu_opcode = r_opcode;
    assign done       = r_done;
    assign result     = r_result;
    assign flag_c     = r_flag_c;
    assign flag_z     = r_flag_z;
    assign err_div0   = r_err_div0;

endmodule : alu_seq_issue
`default_nettype wire
